// File: rtl/serial_slice_adder_pkg.sv
// Shared constants for the serial slice adder: FSM encoding, slice width
// and a small full-adder carry helper used by the 2-bit slice adder.
package serial_slice_adder_pkg;

    // Width of one arithmetic slice processed per clock.
    localparam int SLICE_W = 2;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Majority of three bits: carry out of a single full-adder bit.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        maj3 = (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_slice_adder_if.sv
// Operand/result handshake bundle for the serial slice adder.
// The adder connects through the slave modport; the producer/consumer side
// uses the master modport.
interface serial_slice_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_slice_adder_rca.sv
// 2-bit combinational ripple-carry adder used as the per-cycle slice
// engine of the serial slice adder.
module ripple_carry_adder
    import serial_slice_adder_pkg::*;
(
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    input  logic       i_cin,
    output logic [1:0] o_sum,
    output logic       o_cout
);
    logic w_c0;

    assign o_sum[0] = i_a[0] ^ i_b[0] ^ i_cin;
    assign w_c0     = maj3(i_a[0], i_b[0], i_cin);
    assign o_sum[1] = i_a[1] ^ i_b[1] ^ w_c0;
    assign o_cout   = maj3(i_a[1], i_b[1], w_c0);
endmodule

// File: rtl/serial_slice_adder.sv
// Multi-cycle WIDTH-bit adder: accepts an operand pair, walks it two bits
// per clock through a 2-bit ripple-carry adder with a registered carry,
// and presents the assembled sum/cout until the consumer takes it.
module serial_slice_adder
    import serial_slice_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_slice_adder_if.slave  bus
);
    localparam int SLICES = WIDTH / SLICE_W;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;
    logic             r_busy;

    logic [IDX_W:0]   w_base;
    logic [1:0]       w_slice_a;
    logic [1:0]       w_slice_b;
    logic [1:0]       w_slice_sum;
    logic             w_slice_cout;

    // Bit offset of the current slice (idx * 2).
    assign w_base    = {r_idx, 1'b0};
    assign w_slice_a = r_a[w_base +: SLICE_W];
    assign w_slice_b = r_b[w_base +: SLICE_W];

    ripple_carry_adder u_rca (
        .i_a    (w_slice_a),
        .i_b    (w_slice_b),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    // Sequencer: capture operands, step one slice per clock, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum[w_base +: SLICE_W] <= w_slice_sum;
                    r_carry                  <= w_slice_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_slice_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // Result stays frozen until the consumer takes it.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready must drop the instant reset asserts, so it is gated by rst.
    assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_serial_slice_adder.sv
// Self-checking bench: 8-bit directed and random adds with backpressure and
// mid-operation reset, plus an exhaustive 2-bit instance.
module tb_serial_slice_adder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_slice_adder_if #(.WIDTH(8)) if8 ();
    serial_slice_adder_if #(.WIDTH(2)) if2 ();

    serial_slice_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_slice_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit add, checked against plain arithmetic, with `hold` cycles of backpressure.
    task automatic add8(input logic [7:0] ta, input logic [7:0] tb2, input logic tcin, input int hold);
        logic [8:0] exp;
        int         cyc;
        exp = {1'b0, ta} + {1'b0, tb2} + {8'd0, tcin};
        @(negedge clk);
        check("idle_ready", if8.in_ready, 1'b1);
        if8.a = ta; if8.b = tb2; if8.cin = tcin; if8.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("run_busy", if8.busy, 1'b1);
        check("run_in_ready", if8.in_ready, 1'b0);
        if8.in_valid = 1'b0;
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
        cyc = 0;
        while (!if8.out_valid && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'd4);
        check("sum", if8.sum, exp[7:0]);
        check("cout", if8.cout, exp[8]);
        for (int h = 0; h < hold; h++) begin
            if8.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", if8.out_valid, 1'b1);
            check("bp_sum", if8.sum, exp[7:0]);
            check("bp_cout", if8.cout, exp[8]);
            check("bp_in_ready", if8.in_ready, 1'b0);
        end
        if8.in_valid  = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.out_ready = 1'b0;
        check("post_valid", if8.out_valid, 1'b0);
        check("post_in_ready", if8.in_ready, 1'b1);
        check("post_busy", if8.busy, 1'b0);
    endtask

    initial begin
        logic [2:0] exp2;
        logic [4:0] combo;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if8.in_valid = 1'b0; if8.a = 8'd0; if8.b = 8'd0; if8.cin = 1'b0; if8.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.a = 2'd0; if2.b = 2'd0; if2.cin = 1'b0; if2.out_ready = 1'b0;
        #1;
        check("rst_in_ready", if8.in_ready, 1'b0);
        check("rst_out_valid", if8.out_valid, 1'b0);
        check("rst_busy", if8.busy, 1'b0);
        check("rst_sum", if8.sum, 8'd0);
        check("rst_cout", if8.cout, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_ready", if8.in_ready, 1'b1);

        // Directed adds from the plan, including backpressure of 5 cycles.
        add8(8'h5A, 8'h3C, 1'b0, 0);
        add8(8'hFF, 8'h00, 1'b1, 0);
        add8(8'hFF, 8'hFF, 1'b1, 0);
        add8(8'h5A, 8'h3C, 1'b0, 5);

        // Random adds with light random backpressure.
        for (int n = 0; n < 24; n++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Asynchronous reset two cycles into an add.
        @(negedge clk);
        if8.a = 8'hC3; if8.b = 8'h7E; if8.cin = 1'b1; if8.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", if8.busy, 1'b0);
        check("abort_out_valid", if8.out_valid, 1'b0);
        check("abort_sum", if8.sum, 8'd0);
        check("abort_cout", if8.cout, 1'b0);
        check("abort_in_ready", if8.in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_pulse", if8.out_valid, 1'b0);
        end
        add8(8'h01, 8'h01, 1'b0, 0);

        // Exhaustive 2-bit instance: a single RUN cycle per add.
        for (int i = 0; i < 32; i++) begin
            combo = 5'(i);
            exp2 = {1'b0, combo[1:0]} + {1'b0, combo[3:2]} + {2'd0, combo[4]};
            @(negedge clk);
            if2.a = combo[1:0]; if2.b = combo[3:2]; if2.cin = combo[4]; if2.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if2.in_valid = 1'b0;
            check("w2_not_yet", if2.out_valid, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check("w2_valid", if2.out_valid, 1'b1);
            check("w2_sum", if2.sum, exp2[1:0]);
            check("w2_cout", if2.cout, exp2[2]);
            if2.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if2.out_ready = 1'b0;
            check("w2_idle", if2.in_ready, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_slice_adder.md
Name: serial_slice_adder

Overview:
- Multi-cycle N-bit adder sequencer. Accepts a wide operand pair over a valid/ready handshake.
- Feeds one 2-bit slice per clock into the team's 2-bit ripple_carry_adder. Registers the carry between slices and assembles the full sum.
- Returns the result over a second valid/ready handshake.
- Sits directly upstream of the 2-bit adder, turning it into an area-cheap wide adder for datapaths that tolerate latency.

Parameters:
- WIDTH, 8, operand/sum width in bits. Must be even and >= 2.
- SLICES, WIDTH/2, derived. Number of 2-bit slices and cycles per add. Not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair a/b/cin is valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in to slice 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of the top slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst, clk as named above).
  - While rst is high: state=IDLE, slice index=0, carry=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=0.
  - Takes effect immediately, without a clock edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 (when rst low).
  - On an edge with in_valid=1: latch a, b; carry<=cin; idx<=0; clear sum; go RUN.
  - in_valid=0 holds IDLE.
- RUN:
  - in_ready=0.
  - Each edge: slice idx is a[2idx+1:2idx] + b[2idx+1:2idx] + carry via the 2-bit adder. Write the 2-bit result to sum[2idx+1:2idx] and carry<=slice cout.
  - When idx==SLICES-1: cout<=slice cout, go DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1; sum and cout held stable.
  - Edge with out_ready=1: go IDLE, out_valid drops next cycle.
  - out_ready=0 holds DONE indefinitely, outputs unchanged.
- Latency: acceptance edge E0. Slices complete at E1..E_SLICES. out_valid is high after E_SLICES, i.e. SLICES cycles after acceptance.
- Throughput: one add per SLICES+2 cycles minimum (accept, SLICES run, handoff). No accept in DONE and no bypass, so in_ready=0 in RUN and DONE.
- Operands are captured at accept. Changes on a/b/cin after accept have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Carry propagates only through the registered carry between slices.
- Carry chain: full-chain carry (e.g. all-ones + cin=1) is resolved correctly with no extra cycles.
- SLICES=1 (WIDTH=2): RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE: result is discarded, block returns to IDLE, out_valid never pulses for the aborted add.
- out_ready is ignored outside DONE.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a SLICE_W=2 constant.
- Index width is clog2(SLICES), minimum 1.
- One sub-module instance: the existing ripple_carry_adder (2-bit slice, combinational). Its inputs are muxed by idx and its outputs are registered here.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> out_valid 4 cycles after accept; sum=0x96, cout=0.
- WIDTH=8, a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1 (carry ripples through all 4 slices).
- WIDTH=8, a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: result 0x96 pending, out_ready=0 for 5 cycles -> sum/cout/out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst asynchronously 2 cycles after accept -> immediately state IDLE, sum=0, out_valid=0. After release, a=0x01, b=0x01, cin=0 -> sum=0x02, cout=0.
- WIDTH=2 exhaustive: all 32 a/b/cin combinations -> each result after 1 cycle matches a+b+cin.
